// File: rtl/blinking_light_multi.sv
// NUM_CH independent blink engines sharing a tick enable and configuration bus.
// Each channel latches its timing at start and runs ON/OFF phases for a counted or continuous run.
module blinking_light_multi #(
    parameter int NUM_CH = 4,
    parameter int TIME_W = 8,
    parameter int REP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    input  logic              mode,
    input  logic [TIME_W-1:0] on_time,
    input  logic [TIME_W-1:0] off_time,
    input  logic [REP_W-1:0]  rep_cnt,
    output logic [NUM_CH-1:0] light,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    function automatic logic [TIME_W-1:0] eff_time(input logic [TIME_W-1:0] t);
        return (t == {TIME_W{1'b0}}) ? TIME_W'(1'b1) : t;
    endfunction

    function automatic logic [REP_W-1:0] eff_rep(input logic [REP_W-1:0] r);
        return (r == {REP_W{1'b0}}) ? REP_W'(1'b1) : r;
    endfunction

    function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] c);
        return (c == {REP_W{1'b1}}) ? c : c + REP_W'(1'b1);
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t            state_r, state_s;
        logic [TIME_W-1:0] timer_r, timer_s;
        logic [TIME_W-1:0] on_r, on_s, off_r, off_s;
        logic [REP_W-1:0]  cnt_r, cnt_s, rep_r, rep_s;
        logic [REP_W-1:0]  cnt_inc_s;
        logic              mode_r, mode_s;
        logic              light_r, light_s;
        logic              busy_r, busy_s;
        logic              done_r, done_s;

        // Next-state, timer/counter update and next registered output values
        always_comb begin
            state_s   = state_r;
            timer_s   = timer_r;
            cnt_s     = cnt_r;
            on_s      = on_r;
            off_s     = off_r;
            rep_s     = rep_r;
            mode_s    = mode_r;
            done_s    = 1'b0;
            cnt_inc_s = sat_inc(cnt_r);
            case (state_r)
                ST_IDLE: begin
                    if (start[i] && !stop[i]) begin
                        // Effective (zero-promoted) values are stored so the compares stay simple
                        on_s    = eff_time(on_time);
                        off_s   = eff_time(off_time);
                        rep_s   = eff_rep(rep_cnt);
                        mode_s  = mode;
                        timer_s = {TIME_W{1'b0}};
                        cnt_s   = {REP_W{1'b0}};
                        state_s = ST_ON;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ON: begin
                    if (stop[i]) begin
                        timer_s = {TIME_W{1'b0}};
                        state_s = ST_IDLE;
                    end else if (en) begin
                        if (timer_r == on_r - TIME_W'(1'b1)) begin
                            timer_s = {TIME_W{1'b0}};
                            state_s = ST_OFF;
                        end else begin
                            timer_s = timer_r + TIME_W'(1'b1);
                        end
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_OFF: begin
                    if (stop[i]) begin
                        timer_s = {TIME_W{1'b0}};
                        state_s = ST_IDLE;
                    end else if (en) begin
                        if (timer_r == off_r - TIME_W'(1'b1)) begin
                            timer_s = {TIME_W{1'b0}};
                            cnt_s   = cnt_inc_s;
                            if (!mode_r && (cnt_inc_s == rep_r)) begin
                                done_s  = 1'b1;
                                state_s = ST_IDLE;
                            end else begin
                                state_s = ST_ON;
                            end
                        end else begin
                            timer_s = timer_r + TIME_W'(1'b1);
                        end
                    end else begin
                        state_s = ST_OFF;
                    end
                end
                default: begin
                    timer_s = {TIME_W{1'b0}};
                    cnt_s   = {REP_W{1'b0}};
                    state_s = ST_IDLE;
                end
            endcase
            light_s = (state_s == ST_ON);
            busy_s  = (state_s != ST_IDLE);
        end

        // Channel state, latched configuration and registered outputs
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_r <= ST_IDLE;
                timer_r <= {TIME_W{1'b0}};
                cnt_r   <= {REP_W{1'b0}};
                on_r    <= {TIME_W{1'b0}};
                off_r   <= {TIME_W{1'b0}};
                rep_r   <= {REP_W{1'b0}};
                mode_r  <= 1'b0;
                light_r <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                state_r <= state_s;
                timer_r <= timer_s;
                cnt_r   <= cnt_s;
                on_r    <= on_s;
                off_r   <= off_s;
                rep_r   <= rep_s;
                mode_r  <= mode_s;
                light_r <= light_s;
                busy_r  <= busy_s;
                done_r  <= done_s;
            end
        end

        assign light[i] = light_r;
        assign busy[i]  = busy_r;
        assign done[i]  = done_r;
    end

endmodule

// File: tb/tb_blinking_light_multi.sv
// Bench for blinking_light_multi: tick-countdown reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_blinking_light_multi;
    localparam int NUM_CH = 4;
    localparam int TIME_W = 8;
    localparam int REP_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic [NUM_CH-1:0] start = '0;
    logic [NUM_CH-1:0] stop = '0;
    logic              mode = 1'b0;
    logic [TIME_W-1:0] on_time = '0;
    logic [TIME_W-1:0] off_time = '0;
    logic [REP_W-1:0]  rep_cnt = '0;
    logic [NUM_CH-1:0] light, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a run is "ticks left in this segment" plus "blinks left"
    bit m_run [NUM_CH];
    bit m_lit [NUM_CH];
    bit m_done[NUM_CH];
    bit m_cont[NUM_CH];
    int m_left[NUM_CH];
    int m_blinks[NUM_CH];
    int m_on[NUM_CH];
    int m_off[NUM_CH];

    blinking_light_multi #(.NUM_CH(NUM_CH), .TIME_W(TIME_W), .REP_W(REP_W)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop), .mode(mode),
        .on_time(on_time), .off_time(off_time), .rep_cnt(rep_cnt),
        .light(light), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 1'b0; m_lit[i] = 1'b0; m_done[i] = 1'b0; m_cont[i] = 1'b0;
            m_left[i] = 0; m_blinks[i] = 0; m_on[i] = 0; m_off[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            m_done[i] = 1'b0;
            if (!m_run[i]) begin
                if (start[i] && !stop[i]) begin
                    m_run[i]    = 1'b1;
                    m_lit[i]    = 1'b1;
                    m_cont[i]   = mode;
                    m_on[i]     = (on_time == 8'd0) ? 1 : int'(on_time);
                    m_off[i]    = (off_time == 8'd0) ? 1 : int'(off_time);
                    m_blinks[i] = (rep_cnt == 4'd0) ? 1 : int'(rep_cnt);
                    m_left[i]   = m_on[i];
                end
            end else if (stop[i]) begin
                m_run[i] = 1'b0;
                m_lit[i] = 1'b0;
            end else if (en) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (m_lit[i]) begin
                        m_lit[i]  = 1'b0;
                        m_left[i] = m_off[i];
                    end else begin
                        if (!m_cont[i]) m_blinks[i]--;
                        if (!m_cont[i] && m_blinks[i] == 0) begin
                            m_run[i]  = 1'b0;
                            m_done[i] = 1'b1;
                        end else begin
                            m_lit[i]  = 1'b1;
                            m_left[i] = m_on[i];
                        end
                    end
                end
            end
        end
    endfunction

    // One clock: model follows the edge, DUT outputs compared on the falling edge
    task automatic cycle();
        logic [NUM_CH-1:0] el, eb, ed;
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            el[i] = m_run[i] && m_lit[i];
            eb[i] = m_run[i];
            ed[i] = m_done[i];
        end
        check("light", 32'(light), 32'(el));
        check("busy",  32'(busy),  32'(eb));
        check("done",  32'(done),  32'(ed));
    endtask

    initial begin
        logic [9:0] pat10;
        logic [5:0] pat6;
        logic [2:0] pat3, dpat3;
        int cnt_a, cnt_b, cnt_c;

        model_reset();
        // Reset state
        cycle();
        cycle();
        reset = 1'b1;
        cycle();

        // Async reset in the middle of an ON phase
        en = 1'b1; on_time = 8'd5; off_time = 8'd5; rep_cnt = 4'd1; mode = 1'b0;
        start = 4'b0001;
        cycle();
        start = 4'b0000;
        cycle();
        check("ch0_on_before_reset", 32'(light[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_reset_light", 32'(light), 32'd0);
        check("async_reset_busy",  32'(busy),  32'd0);
        check("async_reset_done",  32'(done),  32'd0);
        cycle();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        check("idle_after_reset", 32'(busy[0]), 32'd0);

        // Counted run: on=3 off=2 rep=2
        on_time = 8'd3; off_time = 8'd2; rep_cnt = 4'd2; mode = 1'b0; en = 1'b1;
        start = 4'b0001;
        pat10 = '0; cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            start = 4'b0000;
            pat10 = {pat10[8:0], light[0]};
            if (busy[0]) cnt_a++;
        end
        check("counted_pattern", 32'(pat10), 32'(10'b1110011100));
        check("counted_busy_cycles", 32'(cnt_a), 32'd10);
        cycle();
        check("counted_done", 32'(done[0]), 32'd1);
        check("counted_busy_end", 32'(busy[0]), 32'd0);
        cycle();

        // Tick gating: en one cycle in four, start cycle carries a tick
        on_time = 8'd2; off_time = 8'd1; rep_cnt = 4'd1;
        start = 4'b0001;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 24; k++) begin
            en = ((k % 4) == 0);
            cycle();
            start = 4'b0000;
            if (light[0]) cnt_a++;
            if (done[0]) cnt_b++;
        end
        check("gated_light_cycles", 32'(cnt_a), 32'd8);
        check("gated_done_count", 32'(cnt_b), 32'd1);
        en = 1'b1;

        // Zero durations and zero repeat count
        on_time = 8'd0; off_time = 8'd0; rep_cnt = 4'd0;
        start = 4'b0001;
        pat3 = '0; dpat3 = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            start = 4'b0000;
            pat3  = {pat3[1:0], light[0]};
            dpat3 = {dpat3[1:0], done[0]};
        end
        check("zero_light_pattern", 32'(pat3), 32'(3'b100));
        check("zero_done_pattern", 32'(dpat3), 32'(3'b001));

        // Maximum ON duration
        on_time = 8'd255; off_time = 8'd1; rep_cnt = 4'd1;
        start = 4'b0001;
        cnt_a = 0;
        for (int k = 0; k < 262; k++) begin
            cycle();
            start = 4'b0000;
            if (light[0]) cnt_a++;
        end
        check("max_on_ticks", 32'(cnt_a), 32'd255);
        check("max_on_idle", 32'(busy[0]), 32'd0);

        // Continuous mode on ch2, then stop while start is held
        mode = 1'b1; on_time = 8'd1; off_time = 8'd1;
        start = 4'b0100;
        pat6 = '0; cnt_b = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            pat6 = {pat6[4:0], light[2]};
            if (done[2]) cnt_b++;
        end
        check("cont_toggle", 32'(pat6), 32'(6'b101010));
        check("cont_no_done", 32'(cnt_b), 32'd0);
        stop = 4'b0100;
        cycle();
        check("stop_light", 32'(light[2]), 32'd0);
        check("stop_busy", 32'(busy[2]), 32'd0);
        check("stop_done", 32'(done[2]), 32'd0);
        cycle();
        cycle();
        check("stop_no_restart", 32'(busy[2]), 32'd0);
        start = 4'b0000; stop = 4'b0000;
        cycle();

        // Independence: ch3 continuous, ch1 counted, config changed mid-run
        mode = 1'b1; on_time = 8'd1; off_time = 8'd2; rep_cnt = 4'd1;
        start = 4'b1000;
        cycle();
        mode = 1'b0; on_time = 8'd2; off_time = 8'd3; rep_cnt = 4'd3;
        start = 4'b0010;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            start = 4'b0000;
            mode = 1'b1; on_time = 8'd7; off_time = 8'd7; rep_cnt = 4'd9;
            if (busy[1]) cnt_a++;
            if (done[1]) cnt_b++;
            if (done[3]) cnt_c++;
        end
        check("indep_ch1_busy", 32'(cnt_a), 32'd15);
        check("indep_ch1_done", 32'(cnt_b), 32'd1);
        check("indep_ch3_done", 32'(cnt_c), 32'd0);
        check("indep_ch3_busy", 32'(busy[3]), 32'd1);
        stop = 4'b1000;
        cycle();
        stop = 4'b0000;
        cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            en    = ($urandom_range(0, 3) != 0);
            start = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) stop[i] = ($urandom_range(0, 19) == 0);
            mode     = ($urandom_range(0, 3) == 0);
            on_time  = TIME_W'($urandom_range(0, 6));
            off_time = TIME_W'($urandom_range(0, 6));
            rep_cnt  = REP_W'($urandom_range(0, 15));
            cycle();
        end
        start = '0; stop = '0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
